pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised program-counter unit: next generation of the CPU's PC block.
- Generalised address width, increment step, reset vector and halt address.
- Adds a hardware return-address stack for call/return, a pipeline stall input, and an explicit RUN/HALT state machine with resume.
- Sits between the decode/branch-resolution logic and the instruction-memory address input.

Parameters:
WIDTH, 32, PC/address width in bits
INCR, 1, sequential increment added to pc (modulo 2^WIDTH)
RESET_VECTOR, 0, pc value loaded on reset
HALT_EN, 1, 1 = halt detection enabled; 0 = never halt
HALT_ADDR, all-ones (WIDTH bits), pc value that triggers HALT
DEPTH, 4, return-address stack entries (>=1)
SP_W, clog2(DEPTH+1), width of stack_depth

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
stall  input  1  hold all state this cycle
branch  input  1  taken branch, load target
jump  input  1  unconditional jump, load target
call  input  1  push pc+INCR, load target
ret  input  1  pop stack into pc
resume  input  1  leave HALT
target  input  WIDTH  branch/jump/call destination (pre-computed pc+imm or absolute)
pc  output  WIDTH  current instruction address
halted  output  1  1 while in HALT
stack_depth  output  SP_W  valid entries in stack (0..DEPTH)
stack_overflow  output  1  sticky: call with stack full
stack_underflow  output  1  sticky: ret with stack empty

Behaviour:
- Reset (reset=0, asynchronous, independent of clock): pc=RESET_VECTOR, state=RUN, stack_depth=0, halted=0, both sticky flags=0. Stack contents need not be cleared. Reset mid-operation (including in HALT or with a pending push) discards all state immediately.
- All other updates occur on rising clock edges with reset=1. Outputs are registered; pc reflects an update one cycle after the controlling inputs are sampled.
- States: RUN, HALT. halted = (state==HALT).
- Priority each edge, highest first: stall > halt detect > ret > call > jump > branch > increment.
- stall=1: pc, state, stack, stack_depth and flags hold, in either state.
- RUN, HALT_EN=1, pc==HALT_ADDR, stall=0: state->HALT; pc holds; control inputs ignored this cycle.
- RUN, ret:
  - depth>0: pc <= stack[depth-1]; depth--.
  - depth==0: stack_underflow <= 1; pc <= pc+INCR.
- RUN, call (ret=0):
  - depth<DEPTH: stack[depth] <= pc+INCR; depth++; pc <= target.
  - depth==DEPTH: stack_overflow <= 1; no push; depth unchanged; pc <= target.
- RUN, jump or branch (ret=call=0): pc <= target. jump and branch together behave as a single load.
- RUN, no control input: pc <= pc+INCR.
- Arithmetic is unsigned modulo 2^WIDTH. pc+INCR wraps silently, e.g. WIDTH=32, pc=FFFFFFFF, INCR=1 -> 00000000 (when HALT_EN=0 or HALT_ADDR differs).
- HALT, stall=0:
  - resume=1: state->RUN; pc <= pc+INCR (steps past HALT_ADDR, so halt does not re-trigger immediately).
  - resume=0: hold.
  - branch/jump/call/ret are ignored in HALT.
- Sticky flags clear only on reset.
- HALT_EN=0: state never leaves RUN; halted=0 permanently.

Test Plan:
- reset=0 then release; 3 idle edges -> pc 0,1,2,3; halted=0; stack_depth=0.
- pc=10, call=1, target=100 -> pc=100, depth=1; next ret=1 -> pc=11, depth=0.
- DEPTH=4: five nested calls (targets 20,30,40,50,60) -> 5th sets stack_overflow=1, depth stays 4; four rets return in LIFO order; 5th ret -> stack_underflow=1, pc increments by 1.
- pc=5, stall=1 with jump=1, target=99 for 2 cycles -> pc stays 5; release stall with jump held -> pc=99.
- jump target=FFFFFFFF (HALT_ADDR) -> next edge halted=1, pc holds FFFFFFFF across 3 edges with branch=1 ignored; resume=1 -> pc=00000000 (wrap), halted=0.
- Assert reset=0 mid-cycle while halted with depth=2 -> pc=RESET_VECTOR, halted=0, depth=0, both flags 0 before the next clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/jump flow, a return-address stack for
// call/return, pipeline stall, and a RUN/HALT state machine with resume.
module pc_sequencer #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  INCR         = WIDTH'(1),
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter bit                HALT_EN      = 1'b1,
  parameter logic [WIDTH-1:0]  HALT_ADDR    = '1,
  parameter int unsigned       DEPTH        = 4,
  parameter int unsigned       SP_W         = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic             resume,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic             halted,
  output logic [SP_W-1:0]  stack_depth,
  output logic             stack_overflow,
  output logic             stack_underflow
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] DepthMax = SP_W'(DEPTH);

  typedef enum logic {StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SP_W-1:0]  depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic             push_en;
  logic [IdxW-1:0]  wr_idx;
  logic [IdxW-1:0]  rd_idx;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc = pc_q + INCR;
  // Top-of-stack lives at depth-1; the next free slot at depth.
  assign wr_idx = IdxW'(depth_q);
  assign rd_idx = IdxW'(depth_q - SP_W'(1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (!stall) begin
      unique case (state_q)
        StRun: begin
          if (HALT_EN && (pc_q == HALT_ADDR)) begin
            state_d = StHalt;
          end else if (ret) begin
            if (depth_q != '0) begin
              pc_d    = stack_q[rd_idx];
              depth_d = depth_q - SP_W'(1);
            end else begin
              unf_d = 1'b1;
              pc_d  = pc_inc;
            end
          end else if (call) begin
            if (depth_q < DepthMax) begin
              push_en = 1'b1;
              depth_d = depth_q + SP_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
            pc_d = target;
          end else if (jump || branch) begin
            pc_d = target;
          end else begin
            pc_d = pc_inc;
          end
        end
        StHalt: begin
          // Stepping past the halt address keeps halt from re-triggering at once.
          if (resume) begin
            state_d = StRun;
            pc_d    = pc_inc;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      pc_q    <= RESET_VECTOR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents carry no reset; depth alone defines which entries are valid.
  always_ff @(posedge clock) begin
    if (push_en) begin
      stack_q[wr_idx] <= pc_inc;
    end
  end

  assign pc              = pc_q;
  assign halted          = (state_q == StHalt);
  assign stack_depth     = depth_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule
